// File: rtl/data_mem_responder_if.sv
// Core data port plus host preload port for data_mem_responder.
// The slave modport is the memory side; the master modport is the core/harness side.
interface data_mem_responder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9
);
  logic [ADDR_W-1:0] data_rom_addr;
  logic              data_write_en;
  logic [DATA_W-1:0] data_rom_write;
  logic [DATA_W-1:0] data_rom_read;
  logic              mem_ready;
  logic              host_req;
  logic              host_valid;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic              host_ready;
  logic              clear_busy;

  modport slave (
    input  data_rom_addr, data_write_en, data_rom_write,
    input  host_req, host_valid, host_addr, host_data,
    output data_rom_read, mem_ready, host_ready, clear_busy
  );

  modport master (
    output data_rom_addr, data_write_en, data_rom_write,
    output host_req, host_valid, host_addr, host_data,
    input  data_rom_read, mem_ready, host_ready, clear_busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// 512x16 data memory with async read / sync write, a post-reset zero-fill engine,
// and a host preload port that takes ownership while the core is held off.
module data_mem_responder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StRun   = 2'd1,
    StLoad  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clear_ptr_q, clear_ptr_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    wr_en       = 1'b0;
    wr_addr     = clear_ptr_q;
    wr_data     = '0;
    unique case (state_q)
      StClear: begin
        wr_en       = 1'b1;
        clear_ptr_d = clear_ptr_q + ADDR_W'(1);
        // A host request pending at the end of the fill goes straight to LOAD.
        if (clear_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = bus.host_req ? StLoad : StRun;
        end
      end
      StRun: begin
        wr_en   = bus.data_write_en;
        wr_addr = bus.data_rom_addr;
        wr_data = bus.data_rom_write;
        if (bus.host_req) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        wr_en   = bus.host_valid;
        wr_addr = bus.host_addr;
        wr_data = bus.host_data;
        if (!bus.host_req) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClear;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  // Array contents survive rst_n; only the clear engine initialises them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign bus.data_rom_read = (state_q == StRun) ? mem[bus.data_rom_addr] : '0;
  assign bus.mem_ready     = (state_q == StRun);
  assign bus.host_ready    = (state_q == StLoad);
  assign bus.clear_busy    = (state_q == StClear);

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed stimulus, a behavioural
// memory/ownership model compared every cycle, and literal spot checks.
module tb_data_mem_responder;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DEPTH  = 512;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  data_mem_responder #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the memory and what each word holds. Zero-fill is treated as
  // instantaneous (contents are invisible until the fill ends); only its length counts.
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_filling;
  bit                m_host_owns;
  int                m_fill_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_filling   = 1'b1;
      m_host_owns = 1'b0;
      m_fill_left = DEPTH;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (m_filling) begin
      m_fill_left--;
      if (m_fill_left == 0) begin
        m_filling   = 1'b0;
        m_host_owns = bus.host_req;
      end
    end else if (m_host_owns) begin
      if (bus.host_valid) m_mem[bus.host_addr] = bus.host_data;
      if (!bus.host_req) m_host_owns = 1'b0;
    end else begin
      if (bus.data_write_en) m_mem[bus.data_rom_addr] = bus.data_rom_write;
      if (bus.host_req) m_host_owns = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_clear_busy", 32'(bus.clear_busy), 32'(m_filling));
      chk("cmp_mem_ready", 32'(bus.mem_ready), 32'(!m_filling && !m_host_owns));
      chk("cmp_host_ready", 32'(bus.host_ready), 32'(!m_filling && m_host_owns));
      chk("cmp_read", 32'(bus.data_rom_read),
          (!m_filling && !m_host_owns) ? 32'(m_mem[bus.data_rom_addr]) : 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Starts mid-cycle; counts cycles with clear_busy high, ends 3 units after an edge.
  task automatic count_clear(output int n);
    n = 0;
    #1;
    while (bus.clear_busy === 1'b1 && n < 2000) begin
      n++;
      @(posedge clk);
      #3;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  int n;

  initial begin
    bus.data_rom_addr  = '0;
    bus.data_write_en  = 1'b0;
    bus.data_rom_write = '0;
    bus.host_req       = 1'b0;
    bus.host_valid     = 1'b0;
    bus.host_addr      = '0;
    bus.host_data      = '0;

    repeat (3) step();
    #1;
    chk("rst_clear_busy", 32'(bus.clear_busy), 32'h1);
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'h0);
    chk("rst_host_ready", 32'(bus.host_ready), 32'h0);
    chk("rst_read", 32'(bus.data_rom_read), 32'h0);
    cmp_en = 1'b1;

    // Zero-fill length and contents.
    step();
    rst_n = 1'b1;
    count_clear(n);
    chk("clear_len", 32'(n), 32'd512);
    chk("run_mem_ready", 32'(bus.mem_ready), 32'h1);
    bus.data_rom_addr = 9'd0;   #1; chk("rd_0", 32'(bus.data_rom_read), 32'h0);
    bus.data_rom_addr = 9'd255; #1; chk("rd_255", 32'(bus.data_rom_read), 32'h0);
    bus.data_rom_addr = 9'd511; #1; chk("rd_511", 32'(bus.data_rom_read), 32'h0);

    // Core write: old value same cycle, new value next cycle.
    step();
    bus.data_rom_addr  = 9'h012;
    bus.data_rom_write = 16'hBEEF;
    bus.data_write_en  = 1'b1;
    #1; chk("wr_same_cycle", 32'(bus.data_rom_read), 32'h0);
    step();
    bus.data_write_en = 1'b0;
    #1; chk("wr_next_cycle", 32'(bus.data_rom_read), 32'hBEEF);

    // Host load of four back-to-back beats; core write during LOAD is dropped.
    step();
    bus.host_req = 1'b1;
    step();
    #1;
    chk("load_mem_ready", 32'(bus.mem_ready), 32'h0);
    chk("load_host_ready", 32'(bus.host_ready), 32'h1);
    chk("load_read", 32'(bus.data_rom_read), 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.host_valid = 1'b1;
      bus.host_addr  = ADDR_W'(9'h100 + i);
      bus.host_data  = DATA_W'(16'hA000 + i);
      bus.data_write_en = (i == 1);
      bus.data_rom_addr  = 9'h100;
      bus.data_rom_write = 16'hDEAD;
      if (i == 3) bus.host_req = 1'b0;
      step();
    end
    bus.host_valid    = 1'b0;
    bus.data_write_en = 1'b0;
    #1; chk("back_to_run", 32'(bus.mem_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      bus.data_rom_addr = ADDR_W'(9'h100 + i);
      #1; chk("load_readback", 32'(bus.data_rom_read), 32'hA000 + 32'(i));
    end

    // Preload the top word, then reset mid-RUN: asynchronous effect, re-clear.
    step();
    bus.host_req = 1'b1;
    step();
    bus.host_valid = 1'b1;
    bus.host_addr  = 9'h1FF;
    bus.host_data  = 16'h1234;
    bus.host_req   = 1'b0;
    step();
    bus.host_valid    = 1'b0;
    bus.data_rom_addr = 9'h1FF;
    #1; chk("preload_1ff", 32'(bus.data_rom_read), 32'h1234);
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_ready", 32'(bus.mem_ready), 32'h0);
    chk("async_rst_clear_busy", 32'(bus.clear_busy), 32'h1);
    chk("async_rst_read", 32'(bus.data_rom_read), 32'h0);
    step();
    rst_n = 1'b1;
    count_clear(n);
    chk("clear_len_rerun", 32'(n), 32'd512);
    #1; chk("rd_1ff_cleared", 32'(bus.data_rom_read), 32'h0);

    // host_req held through reset release: full fill, then LOAD.
    step();
    rst_n        = 1'b0;
    bus.host_req = 1'b1;
    step();
    rst_n = 1'b1;
    count_clear(n);
    chk("clear_len_hostreq", 32'(n), 32'd512);
    chk("post_clear_host_ready", 32'(bus.host_ready), 32'h1);
    chk("post_clear_mem_ready", 32'(bus.mem_ready), 32'h0);
    step();
    bus.host_req = 1'b0;
    step();
    #1; chk("hostreq_back_run", 32'(bus.mem_ready), 32'h1);

    // Reset at clear_ptr=300 with core writes attempted during the fill.
    step();
    rst_n = 1'b0;
    step();
    rst_n              = 1'b1;
    bus.data_write_en  = 1'b1;
    bus.data_rom_addr  = 9'd5;
    bus.data_rom_write = 16'h5555;
    repeat (300) step();
    bus.data_write_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst300_clear_busy", 32'(bus.clear_busy), 32'h1);
    chk("rst300_mem_ready", 32'(bus.mem_ready), 32'h0);
    chk("rst300_host_ready", 32'(bus.host_ready), 32'h0);
    step();
    rst_n = 1'b1;
    count_clear(n);
    chk("clear_len_rst300", 32'(n), 32'd512);
    #1; chk("core_wr_in_clear_dropped", 32'(bus.data_rom_read), 32'h0);

    step();
    step();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
